mips_dmem_ctrl: RTL and testbench

MIPS_DMEM_CTRL -- requirements
Module: mips_dmem_ctrl

---
 rtl/mips_dmem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mips_dmem_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_ctrl.sv
// MIPS data-memory controller: single-port word RAM behind a request/response handshake.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module mips_dmem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_LAST = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [2:0] cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we_p0;
  logic [1:0]        size_p0;
  logic              uns_p0;
  logic [AW+1:0]     addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic [DATA_W-1:0] rdata_p1;
  logic              err_p1;

  logic              accept;
  logic              commit;
  logic              cur_we;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic [AW+1:0]     cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              is_word;
  logic              is_half;
  logic              misaligned;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] new_word;
  logic [DATA_W-1:0] load_val;
  logic              unused_addr_hi;

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic zext);
    logic signed [7:0] sb;
    sb = b;
    if (zext) return {{(DATA_W-8){1'b0}}, b};
    return {{(DATA_W-8){sb[7]}}, sb};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic zext);
    logic signed [15:0] sh;
    sh = h;
    if (zext) return {{(DATA_W-16){1'b0}}, h};
    return {{(DATA_W-16){sh[15]}}, sh};
  endfunction

  assign accept = req_valid && (state == IDLE);
  // The commit edge is the entry into RESP; with no wait states that is the
  // acceptance edge itself, so the live request fields are used while IDLE.
  assign commit = (state != RESP) && (state_nxt == RESP);

  assign cur_we    = (state == IDLE) ? req_we           : we_p0;
  assign cur_size  = (state == IDLE) ? req_size         : size_p0;
  assign cur_uns   = (state == IDLE) ? req_unsigned     : uns_p0;
  assign cur_addr  = (state == IDLE) ? req_addr[AW+1:0] : addr_p0;
  assign cur_wdata = (state == IDLE) ? req_wdata        : wdata_p0;

  assign unused_addr_hi = ^req_addr[31:AW+2];

  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = (WAIT_CYC > 0) ? WAIT : RESP;
      WAIT:    if (cnt == CNT_LAST) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = rdata_p1;
    rsp_err   = err_p1;
  end

  always_ff @(posedge clk1) begin
    if (rst)                                      cnt <= 3'd0;
    else if ((state == WAIT) && (state_nxt == WAIT)) cnt <= cnt + 3'd1;
    else                                          cnt <= 3'd0;
  end

  // Stage p0: request capture at acceptance
  always_ff @(posedge clk1) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      addr_p0  <= req_addr[AW+1:0];
      wdata_p0 <= req_wdata;
    end
  end

  assign is_word = cur_size[1];
  assign is_half = (cur_size == 2'b01);
  assign idx     = cur_addr[AW+1:2];
  assign old_word = mem[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = (is_half && cur_addr[0]) || (is_word && (cur_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane selection ignores the offending low bits, which aligns down when untrapped.
  always_comb begin
    new_word = old_word;
    load_val = old_word;
    if (is_word) begin
      new_word = cur_wdata;
    end else if (is_half) begin
      new_word[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
      load_val = ext_half(old_word[{cur_addr[1], 4'b0000} +: 16], cur_uns);
    end else begin
      new_word[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
      load_val = ext_byte(old_word[{cur_addr[1:0], 3'b000} +: 8], cur_uns);
    end
  end

  // Stage p1: memory commit and response register
  always_ff @(posedge clk1) begin
    if (!rst && commit && cur_we && !misaligned) mem[idx] <= new_word;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (commit) begin
      rdata_p1 <= (cur_we || misaligned) ? '0 : load_val;
      err_p1   <= misaligned;
    end
  end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Scoreboard bench for mips_dmem_ctrl: one instance with one wait state, one with three.
module tb_mips_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  int errors = 0;
  int checks = 0;
  logic [32:0] sb_q [$];

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rd;
  } op_t;

  mips_dmem_ctrl #(.DATA_W(32), .DEPTH(1024), .WAIT_CYC(1)) u_dut (
    .clk1(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mips_dmem_ctrl #(.DATA_W(32), .DEPTH(1024), .WAIT_CYC(3)) u_dut3 (
    .clk1(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic op_t mk(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic err, input logic [31:0] rd);
    op_t o;
    o.we = we; o.size = size; o.uns = uns; o.addr = addr;
    o.wdata = wdata; o.err = err; o.rd = rd;
    return o;
  endfunction

  // Push the expectation, run one handshake with rsp_ready high, and report
  // what came back plus cycles from acceptance to rsp_valid (-1/99 on timeout).
  task automatic xact(input int d, input op_t o,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    sb_q.push_back({o.err, o.rd});
    rd = 'x; er = 1'bx; lat = -1;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = o.we; req_size[d] = o.size;
    req_unsigned[d] = o.uns; req_addr[d] = o.addr; req_wdata[d] = o.wdata;
    rsp_ready[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin req_valid[d] = 1'b0; return; end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rsp_valid[d] !== 1'b1 && lat < 20);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    if (rsp_valid[d] !== 1'b1) lat = 99;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: req_ready=%b rsp_valid=%b rsp_rdata=%h rsp_err=%b, required 1 0 00000000 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
  endtask

  task automatic test_word;
    op_t ops[$];
    logic [31:0] rd; logic er; int lat; logic [32:0] exp;
    ops.push_back(mk(1, 2'b10, 0, 480, 85, 0, 0));
    ops.push_back(mk(0, 2'b10, 0, 480, 0,  0, 85));
    foreach (ops[i]) begin
      xact(0, ops[i], rd, er, lat);
      exp = sb_q.pop_front();
      checks++;
      if (rd !== exp[31:0] || er !== exp[32] || lat != 2) begin
        errors++;
        $display("FAIL word[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=2",
                 i, rd, er, lat, exp[31:0], exp[32]);
      end
    end
  endtask

  task automatic test_byte_lanes;
    op_t ops[$];
    logic [31:0] rd; logic er; int lat; logic [32:0] exp;
    ops.push_back(mk(1, 2'b10, 0, 0, 32'h0,    0, 32'h0));
    ops.push_back(mk(1, 2'b00, 0, 1, 32'hFF,   0, 32'h0));
    ops.push_back(mk(0, 2'b00, 0, 1, 32'h0,    0, 32'hFFFFFFFF));
    ops.push_back(mk(0, 2'b00, 1, 1, 32'h0,    0, 32'h000000FF));
    ops.push_back(mk(0, 2'b10, 0, 0, 32'h0,    0, 32'h0000FF00));
    ops.push_back(mk(1, 2'b01, 0, 2, 32'h8001, 0, 32'h0));
    ops.push_back(mk(0, 2'b01, 0, 2, 32'h0,    0, 32'hFFFF8001));
    ops.push_back(mk(0, 2'b01, 1, 2, 32'h0,    0, 32'h00008001));
    ops.push_back(mk(0, 2'b01, 0, 0, 32'h0,    0, 32'hFFFFFF00));
    ops.push_back(mk(0, 2'b10, 0, 0, 32'h0,    0, 32'h8001FF00));
    ops.push_back(mk(0, 2'b11, 0, 0, 32'h0,    0, 32'h8001FF00));
    ops.push_back(mk(0, 2'b00, 0, 0, 32'h0,    0, 32'h0));
    ops.push_back(mk(0, 2'b00, 0, 3, 32'h0,    0, 32'hFFFFFF80));
    foreach (ops[i]) begin
      xact(0, ops[i], rd, er, lat);
      exp = sb_q.pop_front();
      checks++;
      if (rd !== exp[31:0] || er !== exp[32] || lat != 2) begin
        errors++;
        $display("FAIL byte_lanes[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=2",
                 i, rd, er, lat, exp[31:0], exp[32]);
      end
    end
  endtask

  task automatic test_wrap;
    op_t ops[$];
    logic [31:0] rd; logic er; int lat; logic [32:0] exp;
    ops.push_back(mk(1, 2'b10, 0, 4096 + 8, 7, 0, 0));
    ops.push_back(mk(0, 2'b10, 0, 8,        0, 0, 7));
    foreach (ops[i]) begin
      xact(0, ops[i], rd, er, lat);
      exp = sb_q.pop_front();
      checks++;
      if (rd !== exp[31:0] || er !== exp[32] || lat != 2) begin
        errors++;
        $display("FAIL wrap[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=2",
                 i, rd, er, lat, exp[31:0], exp[32]);
      end
    end
  endtask

  task automatic test_misalign;
    op_t ops[$];
    logic [31:0] rd; logic er; int lat; logic [32:0] exp;
    ops.push_back(mk(1, 2'b10, 0, 4, 32'h11111111, 0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
    ops.push_back(mk(1, 2'b10, 0, 6, 32'hDEADBEEF, 1, 0));
    ops.push_back(mk(0, 2'b10, 0, 4, 0,            0, 32'h11111111));
    ops.push_back(mk(0, 2'b10, 0, 6, 0,            1, 0));
    ops.push_back(mk(0, 2'b01, 0, 5, 0,            1, 0));
`else
    ops.push_back(mk(1, 2'b10, 0, 6, 32'hDEADBEEF, 0, 0));
    ops.push_back(mk(0, 2'b10, 0, 4, 0,            0, 32'hDEADBEEF));
    ops.push_back(mk(0, 2'b10, 0, 6, 0,            0, 32'hDEADBEEF));
    ops.push_back(mk(0, 2'b01, 0, 5, 0,            0, 32'hFFFFBEEF));
`endif
    foreach (ops[i]) begin
      xact(0, ops[i], rd, er, lat);
      exp = sb_q.pop_front();
      checks++;
      if (rd !== exp[31:0] || er !== exp[32] || lat != 2) begin
        errors++;
        $display("FAIL misalign[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=2",
                 i, rd, er, lat, exp[31:0], exp[32]);
      end
    end
  endtask

  task automatic test_reset_abort;
    op_t ops[$];
    logic [31:0] rd; logic er; int lat; logic [32:0] exp;
    ops.push_back(mk(1, 2'b10, 0, 16, 32'hAAAA5555, 0, 0));
    ops.push_back(mk(0, 2'b10, 0, 16, 0,            0, 32'hAAAA5555));
    foreach (ops[i]) begin
      xact(0, ops[i], rd, er, lat);
      exp = sb_q.pop_front();
      checks++;
      if (rd !== exp[31:0] || er !== exp[32] || lat != 2) begin
        errors++;
        $display("FAIL abort_setup[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=2",
                 i, rd, er, lat, exp[31:0], exp[32]);
      end
    end
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'b10;
    req_unsigned[0] = 1'b0; req_addr[0] = 16; req_wdata[0] = 32'h1234;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_wait: req_ready=%b rsp_valid=%b, required 0 0", req_ready[0], rsp_valid[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: req_ready=%b rsp_valid=%b rsp_rdata=%h rsp_err=%b, required 1 0 00000000 0",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
    end
    xact(0, mk(0, 2'b10, 0, 16, 0, 0, 32'hAAAA5555), rd, er, lat);
    exp = sb_q.pop_front();
    checks++;
    if (rd !== exp[31:0] || er !== exp[32] || lat != 2) begin
      errors++;
      $display("FAIL abort_no_write: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=2",
               rd, er, lat, exp[31:0], exp[32]);
    end
  endtask

  task automatic test_stall;
    logic [31:0] rd; logic er; int lat; logic [32:0] exp;
    xact(1, mk(1, 2'b10, 0, 100, 32'h5A5A, 0, 0), rd, er, lat);
    exp = sb_q.pop_front();
    checks++;
    if (rd !== exp[31:0] || er !== exp[32] || lat != 4) begin
      errors++;
      $display("FAIL stall_setup: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=4",
               rd, er, lat, exp[31:0], exp[32]);
    end
    sb_q.push_back({1'b0, 32'h5A5A});
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'b10;
    req_unsigned[1] = 1'b0; req_addr[1] = 100; rsp_ready[1] = 1'b0;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rsp_valid[1] !== 1'b1 && lat < 20);
    exp = sb_q.pop_front();
    checks++;
    if (lat != 4 || rsp_rdata[1] !== exp[31:0]) begin
      errors++;
      $display("FAIL stall_latency: lat=%0d rdata=%h, required lat=4 rdata=%h", lat, rsp_rdata[1], exp[31:0]);
    end
    // A store offered while the response is held must be ignored.
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_wdata[1] = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== exp[31:0] || rsp_err[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: rsp_valid=%b rdata=%h err=%b req_ready=%b, required 1 %h 0 0",
                 i, rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1], exp[31:0]);
      end
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid[1], req_ready[1]);
    end
    xact(1, mk(0, 2'b10, 0, 100, 0, 0, 32'h5A5A), rd, er, lat);
    exp = sb_q.pop_front();
    checks++;
    if (rd !== exp[31:0] || er !== exp[32] || lat != 4) begin
      errors++;
      $display("FAIL stall_no_side_effect: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=4",
               rd, er, lat, exp[31:0], exp[32]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] model [8];
    logic [31:0] rd; logic er; int lat; logic [32:0] exp;
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      xact(0, mk(1, 2'b10, 0, 512 + 4 * i, model[i], 0, 0), rd, er, lat);
      exp = sb_q.pop_front();
      checks++;
      if (rd !== exp[31:0] || er !== exp[32] || lat != 2) begin
        errors++;
        $display("FAIL b2b_store[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=2",
                 i, rd, er, lat, exp[31:0], exp[32]);
      end
    end
    for (int i = 7; i >= 0; i--) begin
      xact(0, mk(0, 2'b10, 0, 512 + 4 * i, 0, 0, model[i]), rd, er, lat);
      exp = sb_q.pop_front();
      checks++;
      if (rd !== exp[31:0] || er !== exp[32] || lat != 2) begin
        errors++;
        $display("FAIL b2b_load[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=2",
                 i, rd, er, lat, exp[31:0], exp[32]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
      req_unsigned[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      rsp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_word;
    test_byte_lanes;
    test_wrap;
    test_misalign;
    test_reset_abort;
    test_stall;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
